// File: rtl/clk_rst_pkg.sv
// Shared clock/reset types and defaults used by the reset sequencer and its helpers.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SEQ       = 2'd1,
    DONE      = 2'd2,
    ASSERT    = 2'd3
  } rst_seq_state_e;

  localparam int unsigned DEF_NUM_STAGES  = 4;
  localparam int unsigned DEF_STAGE_DELAY = 16;
  localparam int unsigned DEF_MIN_ASSERT  = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered multi-stage reset release gated by PLL lock, with a software-triggered re-reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | all stages held in reset until the synchronized lock is seen
// SEQ       | releasing stages one by one, STAGE_DELAY cycles apart
// DONE      | every stage released
// ASSERT    | software reset: all stages held for at least MIN_ASSERT cycles
module reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int unsigned MIN_ASSERT  = DEF_MIN_ASSERT
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  pll_lock_i,
  input  logic                  sw_rst_req_i,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam int unsigned CW = $clog2(max_u(STAGE_DELAY, MIN_ASSERT));
  localparam int unsigned IW = $clog2(NUM_STAGES);

  localparam logic [CW-1:0] SD_RELOAD = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] MA_RELOAD = CW'(MIN_ASSERT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

  rst_seq_state_e        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_d;
  logic                  done_d, busy_d;
  logic                  lock_s;

  lock_sync u_lock_sync (
    .clk (clk),
    .rst (rst_i),
    .d   (pll_lock_i),
    .q   (lock_s)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_o   <= '1;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_o   <= rst_d;
      done_o  <= done_d;
      busy_o  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_o;

    case (state_q)
      WAIT_LOCK: begin
        rst_d = '1;
        if (lock_s) begin
          state_d = SEQ;
          idx_d   = '0;
          cnt_d   = SD_RELOAD;
        end
      end

      SEQ, DONE: begin
        // Lock loss outranks a software request arriving on the same edge.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          rst_d   = '1;
        end else if (sw_rst_req_i) begin
          state_d = ASSERT;
          rst_d   = '1;
          cnt_d   = MA_RELOAD;
        end else if (state_q == SEQ) begin
          if (cnt_q == '0) begin
            rst_d[idx_q] = 1'b0;
            cnt_d        = SD_RELOAD;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      ASSERT: begin
        rst_d = '1;
        if (sw_rst_req_i) begin
          cnt_d = MA_RELOAD;
        end else if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        rst_d   = '1;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d == SEQ) || (state_d == ASSERT);
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: behavioural model compared every cycle plus directed literal checks.
module tb_reset_sequencer;

  localparam int NS = 4;
  localparam int SD = 16;
  localparam int MA = 8;

  localparam int M_WAIT   = 0;
  localparam int M_SEQ    = 1;
  localparam int M_DONE   = 2;
  localparam int M_ASSERT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_lock_i = 1'b0;
  logic          sw_rst_req_i = 1'b0;
  logic [NS-1:0] rst_o;
  logic          done_o;
  logic          busy_o;

  int n_cmp = 0;
  int n_err = 0;

  int m_mode = M_WAIT;
  int m_t    = 0;
  int m_hold = 0;
  bit ls1    = 1'b0;
  bit ls2    = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES  (NS),
    .STAGE_DELAY (SD),
    .MIN_ASSERT  (MA)
  ) dut (
    .clk          (clk),
    .rst_i        (rst),
    .pll_lock_i   (pll_lock_i),
    .sw_rst_req_i (sw_rst_req_i),
    .rst_o        (rst_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  // Stage k is out of reset once (k+1)*SD cycles have elapsed in sequencing.
  function automatic logic [NS-1:0] exp_rst();
    logic [NS-1:0] v;
    v = '1;
    if (m_mode == M_DONE) v = '0;
    else if (m_mode == M_SEQ)
      for (int k = 0; k < NS; k++) v[k] = !(m_t >= (k + 1) * SD);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = M_WAIT; m_t = 0; m_hold = 0; ls1 = 1'b0; ls2 = 1'b0;
      end else begin
        case (m_mode)
          M_WAIT: if (ls2) begin m_mode = M_SEQ; m_t = 0; end
          M_SEQ, M_DONE: begin
            if (!ls2) m_mode = M_WAIT;
            else if (sw_rst_req_i) begin m_mode = M_ASSERT; m_hold = MA; end
            else if (m_mode == M_SEQ) begin
              m_t++;
              if (m_t == NS * SD) m_mode = M_DONE;
            end
          end
          default: begin
            if (sw_rst_req_i) m_hold = MA;
            else begin
              m_hold--;
              if (m_hold == 0) m_mode = M_WAIT;
            end
          end
        endcase
        ls2 = ls1;
        ls1 = pll_lock_i;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_rst_o", rst_o, exp_rst());
      check("model_done_o", done_o, m_mode == M_DONE);
      check("model_busy_o", busy_o, (m_mode == M_SEQ) || (m_mode == M_ASSERT));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Waits for a fresh SEQ entry: busy low (WAIT_LOCK) then busy high.
  task automatic wait_seq(input string name);
    for (int i = 0; i < 40 && busy_o; i++) tick(1);
    for (int i = 0; i < 40 && !busy_o; i++) tick(1);
    check(name, busy_o, 1);
  endtask

  initial begin
    #23;
    check("reset_rst_o", rst_o, 4'hF);
    check("reset_done_o", done_o, 0);
    check("reset_busy_o", busy_o, 0);
    @(posedge clk); #2;
    rst = 1'b0; pll_lock_i = 1'b1;

    // Power-up sequence with defaults
    wait_seq("a_entry");
    tick(15); check("a_pre_bit0", rst_o, 4'hF);
    tick(1);  check("a_bit0", rst_o, 4'hE);
    tick(16); check("a_bit1", rst_o, 4'hC);
    tick(16); check("a_bit2", rst_o, 4'h8);
    tick(16); check("a_bit3", rst_o, 4'h0);
    check("a_done", done_o, 1);
    check("a_busy", busy_o, 0);

    // Software reset pulse from DONE
    sw_rst_req_i = 1'b1; tick(1); sw_rst_req_i = 1'b0;
    check("b_rst_o", rst_o, 4'hF);
    check("b_done", done_o, 0);
    check("b_busy", busy_o, 1);
    tick(7); check("b_hold_end", busy_o, 1);
    tick(1); check("b_wait", busy_o, 0);
    tick(1); check("b_seq", busy_o, 1);
    tick(64);
    check("b_done2", done_o, 1);
    check("b_rst_o2", rst_o, 4'h0);

    // Lock loss at cycle 40 of SEQ
    sw_rst_req_i = 1'b1; tick(1); sw_rst_req_i = 1'b0;
    wait_seq("c_entry");
    tick(40); check("c_at40", rst_o, 4'hC);
    pll_lock_i = 1'b0;
    tick(2); check("c_sync_lag", rst_o, 4'hC);
    tick(1); check("c_lost", rst_o, 4'hF);
    check("c_busy", busy_o, 0);
    tick(30); check("c_held", rst_o, 4'hF);

    // Asynchronous reset mid-SEQ
    pll_lock_i = 1'b1;
    wait_seq("d_entry");
    tick(20); check("d_mid", rst_o, 4'hE);
    #1 rst = 1'b1;
    #1;
    check("d_async_rst_o", rst_o, 4'hF);
    check("d_async_done", done_o, 0);
    check("d_async_busy", busy_o, 0);
    tick(2); rst = 1'b0;
    wait_seq("d_restart");
    tick(16); check("d_bit0", rst_o, 4'hE);

    // Simultaneous lock loss and software request in DONE
    tick(48); check("e_done", done_o, 1);
    pll_lock_i = 1'b0;
    tick(2); sw_rst_req_i = 1'b1;
    tick(1); sw_rst_req_i = 1'b0;
    check("e_not_assert", busy_o, 0);
    check("e_rst_o", rst_o, 4'hF);
    check("e_done_clr", done_o, 0);
    sw_rst_req_i = 1'b1; tick(3);
    check("e_sw_ignored", busy_o, 0);
    sw_rst_req_i = 1'b0;

    // Held software request extends ASSERT
    pll_lock_i = 1'b1;
    wait_seq("f_entry");
    sw_rst_req_i = 1'b1; tick(1);
    check("f_assert", rst_o, 4'hF);
    tick(20); sw_rst_req_i = 1'b0;
    check("f_held", rst_o, 4'hF);
    tick(7); check("f_hold_end", busy_o, 1);
    check("f_hold_rst", rst_o, 4'hF);
    tick(1); check("f_wait", busy_o, 0);
    tick(1); check("f_seq", busy_o, 1);
    tick(16); check("f_bit0", rst_o, 4'hE);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
